// File: rtl/mult_div_unit.sv
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV,
//                DIVU) with HI/LO result registers, MTHI/MTLO write port and
//                a Busy/Done handshake for hazard stalling.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HiWrite,
    input  logic        LoWrite,
    input  logic [31:0] WD,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [5:0]  count;
    logic [1:0]  op_q;
    logic        sign_a;
    logic        sign_b;
    logic        div_zero;
    logic [31:0] a_orig;
    // Multiplicand for MULT*, divisor for DIV*
    logic [31:0] opnd;
    // MULT*: {partial product, remaining multiplier bits}
    // DIV* : {partial remainder, dividend/quotient shift register}
    logic [63:0] acc;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic        neg_res;
    logic        neg_rem;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

    // Operand magnitudes: signed ops strip the sign, unsigned ops pass through
    always_comb begin
        a_mag = A;
        b_mag = B;
        if (!Op[0]) begin
            if (A[31]) a_mag = -A;
            if (B[31]) b_mag = -B;
        end
    end

    // One shift-add step and one restoring-divide step, plus FIX-cycle results
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};

        // Trial subtract of the divisor from {remainder, next dividend bit};
        // bit 33 set means it borrowed and the remainder is restored
        div_diff = {1'b0, acc[63:31]} - {2'b00, opnd};
        if (div_diff[33])
            div_next = {acc[62:0], 1'b0};
        else
            div_next = {div_diff[31:0], acc[30:0], 1'b1};

        neg_res = !op_q[0] && (sign_a ^ sign_b);
        neg_rem = !op_q[0] && sign_a;
        prod    = neg_res ? -acc : acc;
        quo     = neg_res ? -acc[31:0] : acc[31:0];
        rem     = neg_rem ? -acc[63:32] : acc[63:32];

        if (op_q[1]) begin
            hi_res = div_zero ? a_orig : rem;
            lo_res = div_zero ? 32'hFFFF_FFFF : quo;
        end else begin
            hi_res = prod[63:32];
            lo_res = prod[31:0];
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: 32 CALC iterations, then a single FIX cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = CALC;
            CALC:    if (count == 6'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, HI/LO registers and handshake outputs
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            count    <= 6'd0;
            op_q     <= 2'b00;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            a_orig   <= 32'd0;
            opnd     <= 32'd0;
            acc      <= 64'd0;
            HI       <= 32'd0;
            LO       <= 32'd0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Busy <= (state_next != IDLE);
            Done <= (state == FIX);
            case (state)
                IDLE: begin
                    // Direct writes only while idle; a same-cycle Start still
                    // launches and its result overwrites these at FIX
                    if (HiWrite) HI <= WD;
                    if (LoWrite) LO <= WD;
                    if (Start) begin
                        op_q     <= Op;
                        sign_a   <= A[31];
                        sign_b   <= B[31];
                        div_zero <= (B == 32'd0);
                        a_orig   <= A;
                        count    <= 6'd0;
                        if (Op[1]) begin
                            opnd <= b_mag;
                            acc  <= {32'd0, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= {32'd0, b_mag};
                        end
                    end
                end
                CALC: begin
                    count <= count + 6'd1;
                    acc   <= op_q[1] ? div_next : mul_next;
                end
                FIX: begin
                    HI <= hi_res;
                    LO <= lo_res;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
